net_run_sequencer: RTL and testbench
====================================

Name: net_run_sequencer

Overview:
- Command-level controller ahead of network_source. Accepts host commands (APPLY inputs, CLEAR network, RUN n cycles) and expands them into the source beat stream {opcode, charges}.
- Drives network_source through its src_valid/src_ready handshake and reports RUN completion on a done channel.
- Lets the host issue one RUN command instead of n individual zero-input beats.

Parameters:
- NUM_INP, 8, number of network inputs
- CHARGE_WIDTH, 8, signed charge width per input
- RUN_WIDTH, 16, width of RUN cycle count

Ports:
- clk  input  1  system clock
- arstn  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted this cycle when cmd_valid && cmd_ready
- cmd_op  input  2  0=APPLY, 1=CLEAR, 2=RUN, 3=reserved
- cmd_run  input  RUN_WIDTH  RUN cycle count, unsigned
- cmd_inp  input  NUM_INP*CHARGE_WIDTH  APPLY charges, input 0 in MSBs
- src_valid  output  1  beat to network_source
- src_ready  input  1  network_source ready
- src  output  1+NUM_INP*CHARGE_WIDTH  MSB = opcode (0 NOM, 1 CLR), then charges, input 0 first
- done_valid  output  1  RUN completed
- done_ready  input  1  host accepts completion
- done_count  output  RUN_WIDTH  beats issued by the completed RUN
- stall_cnt  output  32  source back-pressure cycles (see Optional Feature)

Behaviour:
- Reset (arstn=0, asynchronous): state=IDLE, cmd_ready=0 while reset is held, src_valid=0, src=0, done_valid=0, done_count=0, run counter=0, stall_cnt=0. Reset mid-RUN aborts the RUN. No done is reported and no further beats are issued.
- States: IDLE, ISSUE, RUN, DONE.
- IDLE: cmd_ready=1, all other states: cmd_ready=0.
- Command accepted in cycle t:
  - APPLY -> ISSUE with src={0,cmd_inp}.
  - CLEAR -> ISSUE with src={1, zeros}.
  - RUN with cmd_run>0 -> RUN, counter=cmd_run, src={0, zeros}.
  - RUN with cmd_run=0 -> DONE, done_count=0.
  - reserved -> consumed, stays IDLE, no beat issued.
- First src_valid is asserted in cycle t+1 (registered, 1-cycle latency).
- ISSUE: src_valid=1, src held stable. On src_ready, return to IDLE. The earliest next command is accepted the cycle after.
- RUN: src_valid=1 continuously. Each src_valid && src_ready decrements the counter. The handshake where counter==1 is the last beat, then -> DONE with done_count=cmd_run. Back-pressure stalls the counter without losing beats.
- DONE: done_valid=1, done_count stable until done_ready, then -> IDLE.
- Handshake rules:
  - src and src_valid never change while src_valid && !src_ready.
  - done_valid never drops without done_ready.
  - No combinational path from src_ready or done_ready to any output.
- Exactly n source handshakes per RUN n. RUN_WIDTH all-ones is legal (65535 beats, no wrap).
- Commands never overlap. A new command is accepted only in IDLE, so a CLEAR issued after a RUN is always ordered after that RUN's last beat and its done.

Optional Feature:
- Macro: NET_RUN_SEQ_STALL_CNT_EN
- Defined: stall_cnt is a 32-bit counter.
  - Increments every cycle with src_valid && !src_ready.
  - Saturates at 0xFFFFFFFF.
  - Reset to 0 by arstn and on acceptance of a CLEAR command; the clear takes priority over an increment in the same cycle.
- Not defined: stall_cnt tied to 0, no counter logic synthesized.

Test Plan:
- Reset, then APPLY with cmd_inp=0x01_02_..._08 and src_ready=1 -> exactly 1 beat, src={0,0x0102030405060708} one cycle after acceptance; cmd_ready high again the following cycle.
- CLEAR with src_ready=1 -> exactly 1 beat with src MSB=1 and charges 0; no done_valid.
- RUN 5, src_ready toggling 1,0,1,0,... -> 5 handshakes, src held stable during stalls, then done_valid=1 with done_count=5 held 3 cycles until done_ready; cmd_ready=0 throughout. With NET_RUN_SEQ_STALL_CNT_EN, stall_cnt=4.
- RUN 0 -> no src_valid, done_valid next cycle with done_count=0; cmd_op=3 -> consumed, no beat, no done.
- Assert arstn=0 after 2 of 10 RUN beats -> src_valid and done_valid drop immediately. After release, IDLE with cmd_ready=1 and no residual beats.
- RUN 65535 with src_ready=1 -> exactly 65535 beats, done_count=0xFFFF.

Source files
------------

// File: rtl/net_run_sequencer.sv
// net_run_sequencer: expands host commands (APPLY / CLEAR / RUN n) into the
// {opcode, charges} beat stream consumed by network_source, and reports the
// completion of each RUN on a separate done channel.
// Optional feature macro: NET_RUN_SEQ_STALL_CNT_EN enables the 32-bit
// source back-pressure counter on stall_cnt (otherwise stall_cnt is 0).
module net_run_sequencer #(
    parameter int NUM_INP      = 8,
    parameter int CHARGE_WIDTH = 8,
    parameter int RUN_WIDTH    = 16
) (
    input  logic                              clk,
    input  logic                              arstn,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [1:0]                        cmd_op,
    input  logic [RUN_WIDTH-1:0]              cmd_run,
    input  logic [NUM_INP*CHARGE_WIDTH-1:0]   cmd_inp,
    output logic                              src_valid,
    input  logic                              src_ready,
    output logic [NUM_INP*CHARGE_WIDTH:0]     src,
    output logic                              done_valid,
    input  logic                              done_ready,
    output logic [RUN_WIDTH-1:0]              done_count,
    output logic [31:0]                       stall_cnt
);

    localparam int CW = NUM_INP * CHARGE_WIDTH;

    localparam logic [1:0] OP_APPLY = 2'd0;
    localparam logic [1:0] OP_CLEAR = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd2;

    localparam logic [RUN_WIDTH-1:0] RUN_ONE = {{(RUN_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW:0]            src_q, src_d;
    logic                   src_valid_q, src_valid_d;
    logic                   done_valid_q, done_valid_d;
    logic [RUN_WIDTH-1:0]   done_count_q, done_count_d;
    logic [RUN_WIDTH-1:0]   run_cnt_q, run_cnt_d;
    logic                   cmd_fire;

    // Commands are only taken in IDLE, and never while reset is held.
    assign cmd_ready = (state_q == S_IDLE) && arstn;
    assign cmd_fire  = cmd_valid && cmd_ready;

    assign src        = src_q;
    assign src_valid  = src_valid_q;
    assign done_valid = done_valid_q;
    assign done_count = done_count_q;

    // State and output registers; every output is registered so ready inputs never reach an output combinationally.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            src_valid_q  <= 1'b0;
            done_valid_q <= 1'b0;
            done_count_q <= '0;
            run_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            src_valid_q  <= src_valid_d;
            done_valid_q <= done_valid_d;
            done_count_q <= done_count_d;
            run_cnt_q    <= run_cnt_d;
        end
    end

    // Next-state logic: decode commands in IDLE, hold beats until accepted, count RUN beats down to the last one.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        src_valid_d  = src_valid_q;
        done_valid_d = done_valid_q;
        done_count_d = done_count_q;
        run_cnt_d    = run_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_APPLY: begin
                            state_d     = S_ISSUE;
                            src_d       = {1'b0, cmd_inp};
                            src_valid_d = 1'b1;
                        end
                        OP_CLEAR: begin
                            state_d     = S_ISSUE;
                            src_d       = {1'b1, {CW{1'b0}}};
                            src_valid_d = 1'b1;
                        end
                        OP_RUN: begin
                            done_count_d = cmd_run;
                            if (cmd_run != '0) begin
                                state_d     = S_RUN;
                                run_cnt_d   = cmd_run;
                                src_d       = '0;
                                src_valid_d = 1'b1;
                            end else begin
                                state_d      = S_DONE;
                                done_valid_d = 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                if (src_ready) begin
                    state_d     = S_IDLE;
                    src_valid_d = 1'b0;
                end
            end
            S_RUN: begin
                if (src_ready) begin
                    run_cnt_d = run_cnt_q - RUN_ONE;
                    if (run_cnt_q == RUN_ONE) begin
                        state_d      = S_DONE;
                        src_valid_d  = 1'b0;
                        done_valid_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (done_ready) begin
                    state_d      = S_IDLE;
                    done_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef NET_RUN_SEQ_STALL_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of cycles where a beat is offered but not taken; a CLEAR command restarts it.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            stall_q <= '0;
        end else if (cmd_fire && (cmd_op == OP_CLEAR)) begin
            stall_q <= '0;
        end else if (src_valid_q && !src_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_net_run_sequencer.sv
// tb_net_run_sequencer: self-checking bench for net_run_sequencer.
// Each command is driven, its beats/done events are collected and compared
// to expectations derived from the command semantics (a hand-written table,
// then random commands fed through a transaction-level model).
module tb_net_run_sequencer;

    localparam int NUM_INP      = 8;
    localparam int CHARGE_WIDTH = 8;
    localparam int RUN_WIDTH    = 16;
    localparam int CW           = NUM_INP * CHARGE_WIDTH;

    logic                  clk;
    logic                  arstn;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [RUN_WIDTH-1:0]  cmd_run;
    logic [CW-1:0]         cmd_inp;
    logic                  src_valid;
    logic                  src_ready;
    logic [CW:0]           src;
    logic                  done_valid;
    logic                  done_ready;
    logic [RUN_WIDTH-1:0]  done_count;
    logic [31:0]           stall_cnt;

    net_run_sequencer #(
        .NUM_INP      (NUM_INP),
        .CHARGE_WIDTH (CHARGE_WIDTH),
        .RUN_WIDTH    (RUN_WIDTH)
    ) dut (
        .clk        (clk),
        .arstn      (arstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_run    (cmd_run),
        .cmd_inp    (cmd_inp),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src        (src),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_count (done_count),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]           op;
        logic [RUN_WIDTH-1:0] run;
        logic [CW-1:0]        inp;
        int                   ready_mode;
        int                   done_delay;
        int                   exp_beats;
        logic [CW:0]          exp_first;
        bit                   exp_done;
        logic [RUN_WIDTH-1:0] exp_dcount;
    } vec_t;

    typedef struct {
        int                   beats;
        logic [CW:0]          first_src;
        logic [CW:0]          src_or;
        int                   first_valid;
        int                   first_done;
        bit                   saw_done;
        logic [RUN_WIDTH-1:0] dcount;
        int                   last_hs;
        int                   end_cyc;
        int                   viol;
        bit                   timeout;
    } res_t;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_stall   = 32'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [79:0] actual, input logic [79:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Transaction-level expectation of one command.
    task automatic model_cmd(input logic [1:0] op, input logic [RUN_WIDTH-1:0] run, input logic [CW-1:0] inp,
                             output int beats, output logic [CW:0] first, output bit done,
                             output logic [RUN_WIDTH-1:0] dcount);
        beats  = 0;
        first  = '0;
        done   = 1'b0;
        dcount = '0;
        case (op)
            2'd0: begin beats = 1; first = {1'b0, inp}; end
            2'd1: begin beats = 1; first = {1'b1, {CW{1'b0}}}; end
            2'd2: begin beats = int'(run); done = 1'b1; dcount = run; end
            default: begin end
        endcase
    endtask

    // Issue one command and drive it to completion, recording what the DUT did.
    task automatic apply_stimulus(input logic [1:0] op, input logic [RUN_WIDTH-1:0] run, input logic [CW-1:0] inp,
                                  input int ready_mode, input int done_delay, output res_t r);
        int budget;
        int cyc;
        int wait_cnt;
        int done_seen;
        int streak;
        bit toggle;
        bit pend_src;
        bit pend_done;
        bit fin;
        logic [CW:0]          held_src;
        logic [RUN_WIDTH-1:0] held_dcount;

        r.beats = 0; r.first_src = '0; r.src_or = '0; r.first_valid = 0; r.first_done = 0;
        r.saw_done = 1'b0; r.dcount = '0; r.last_hs = 0; r.end_cyc = 0; r.viol = 0; r.timeout = 1'b0;
        budget = 5 * (int'(run) + 1) + done_delay + 20;
        done_seen = 0; streak = 0; toggle = 1'b0; pend_src = 1'b0; pend_done = 1'b0; fin = 1'b0;
        held_src = '0; held_dcount = '0;
        src_ready = 1'b0;
        done_ready = 1'b0;

        wait_cnt = 0;
        while (!cmd_ready && wait_cnt < 100) begin
            tick();
            wait_cnt++;
        end

        if (!cmd_ready) begin
            r.timeout = 1'b1;
        end else begin
            cmd_valid = 1'b1;
            cmd_op    = op;
            cmd_run   = run;
            cmd_inp   = inp;
            if (op == 2'd1) exp_stall = 32'd0;
            tick();
            cmd_valid = 1'b0;
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_run   = RUN_WIDTH'($urandom);
            cmd_inp   = {$urandom, $urandom};
            cyc = 1;
            while (!fin && cyc <= budget) begin
                if (pend_src && (!src_valid || src !== held_src)) r.viol++;
                if (pend_done && (!done_valid || done_count !== held_dcount)) r.viol++;
                pend_src  = 1'b0;
                pend_done = 1'b0;
                if ((src_valid || done_valid) && cmd_ready) r.viol++;
                if (src_valid && done_valid) r.viol++;
                if (cmd_ready && !src_valid && !done_valid) begin
                    fin = 1'b1;
                    r.end_cyc = cyc;
                end else begin
                    src_ready  = 1'b0;
                    done_ready = 1'b0;
                    if (src_valid) begin
                        if (r.first_valid == 0) r.first_valid = cyc;
                        case (ready_mode)
                            0: src_ready = 1'b1;
                            1: begin src_ready = !toggle; toggle = !toggle; end
                            default: src_ready = (streak >= 3) || ($urandom_range(0, 2) != 0);
                        endcase
                        if (src_ready) begin
                            if (r.beats == 0) r.first_src = src;
                            r.src_or |= src;
                            r.beats++;
                            r.last_hs = cyc;
                            streak = 0;
                        end else begin
                            streak++;
                            exp_stall = exp_stall + 32'd1;
                            pend_src = 1'b1;
                            held_src = src;
                        end
                    end
                    if (done_valid) begin
                        if (!r.saw_done) begin
                            r.saw_done   = 1'b1;
                            r.dcount     = done_count;
                            r.first_done = cyc;
                        end
                        done_seen++;
                        if (done_seen > done_delay) begin
                            done_ready = 1'b1;
                            r.last_hs  = cyc;
                        end else begin
                            pend_done   = 1'b1;
                            held_dcount = done_count;
                        end
                    end
                    tick();
                    cyc++;
                end
            end
            if (!fin) r.timeout = 1'b1;
        end
        src_ready  = 1'b0;
        done_ready = 1'b0;
    endtask

    // Compare one recorded command against its expectation.
    task automatic check_result(input string tag, input int exp_beats, input logic [CW:0] exp_first,
                                input bit exp_done, input logic [RUN_WIDTH-1:0] exp_dcount, input res_t r);
        check_output({tag, ".timeout"}, 80'(r.timeout), 80'd0);
        check_output({tag, ".beats"}, 80'(r.beats), 80'(exp_beats));
        if (exp_beats > 0) begin
            check_output({tag, ".first_src"}, 80'(r.first_src), 80'(exp_first));
            check_output({tag, ".all_src"}, 80'(r.src_or), 80'(exp_first));
            check_output({tag, ".src_latency"}, 80'(r.first_valid), 80'd1);
        end
        check_output({tag, ".done_seen"}, 80'(r.saw_done), 80'(exp_done));
        if (exp_done) begin
            check_output({tag, ".done_count"}, 80'(r.dcount), 80'(exp_dcount));
            if (exp_beats == 0) check_output({tag, ".done_latency"}, 80'(r.first_done), 80'd1);
        end
        check_output({tag, ".protocol"}, 80'(r.viol), 80'd0);
        check_output({tag, ".idle_return"}, 80'(r.end_cyc), 80'((r.last_hs > 0) ? r.last_hs + 1 : 1));
`ifdef NET_RUN_SEQ_STALL_CNT_EN
        check_output({tag, ".stall_cnt"}, 80'(stall_cnt), 80'(exp_stall));
`else
        check_output({tag, ".stall_cnt"}, 80'(stall_cnt), 80'd0);
`endif
    endtask

    initial begin
        vec_t        table_v [7];
        res_t        r;
        int          m_beats;
        logic [CW:0] m_first;
        bit          m_done;
        logic [RUN_WIDTH-1:0] m_dcount;
        logic [1:0]  rop;
        logic [RUN_WIDTH-1:0] rrun;
        logic [CW-1:0] rinp;
        int          hs;
        int          bad;

        table_v[0] = '{2'd0, 16'd0, 64'h0102030405060708, 0, 0, 1, 65'h0_0102030405060708, 1'b0, 16'd0};
        table_v[1] = '{2'd1, 16'd0, 64'hFFFFFFFFFFFFFFFF, 0, 0, 1, 65'h1_0000000000000000, 1'b0, 16'd0};
        table_v[2] = '{2'd2, 16'd5, 64'h0, 1, 2, 5, 65'h0, 1'b1, 16'd5};
        table_v[3] = '{2'd2, 16'd0, 64'h0, 0, 0, 0, 65'h0, 1'b1, 16'd0};
        table_v[4] = '{2'd3, 16'd7, 64'h1234, 0, 0, 0, 65'h0, 1'b0, 16'd0};
        table_v[5] = '{2'd0, 16'd0, 64'h80FF7F0011223344, 2, 0, 1, 65'h0_80FF7F0011223344, 1'b0, 16'd0};
        table_v[6] = '{2'd2, 16'd3, 64'h0, 2, 1, 3, 65'h0, 1'b1, 16'd3};

        arstn      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 2'd0;
        cmd_run    = '0;
        cmd_inp    = '0;
        src_ready  = 1'b0;
        done_ready = 1'b0;

        tick();
        tick();
        check_output("reset.cmd_ready", 80'(cmd_ready), 80'd0);
        check_output("reset.src_valid", 80'(src_valid), 80'd0);
        check_output("reset.src", 80'(src), 80'd0);
        check_output("reset.done_valid", 80'(done_valid), 80'd0);
        check_output("reset.done_count", 80'(done_count), 80'd0);
        check_output("reset.stall_cnt", 80'(stall_cnt), 80'd0);
        arstn = 1'b1;
        tick();
        check_output("reset.idle_ready", 80'(cmd_ready), 80'd1);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(table_v[i].op, table_v[i].run, table_v[i].inp,
                           table_v[i].ready_mode, table_v[i].done_delay, r);
            check_result($sformatf("table%0d", i), table_v[i].exp_beats, table_v[i].exp_first,
                         table_v[i].exp_done, table_v[i].exp_dcount, r);
        end

        for (int i = 0; i < 40; i++) begin
            rop  = 2'($urandom_range(0, 3));
            rrun = RUN_WIDTH'($urandom_range(0, 12));
            rinp = {$urandom, $urandom};
            model_cmd(rop, rrun, rinp, m_beats, m_first, m_done, m_dcount);
            apply_stimulus(rop, rrun, rinp, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), r);
            check_result($sformatf("rand%0d", i), m_beats, m_first, m_done, m_dcount, r);
        end

        // Reset in the middle of a RUN 10 after two accepted beats.
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_run   = 16'd10;
        tick();
        cmd_valid = 1'b0;
        src_ready = 1'b1;
        hs = 0;
        for (int k = 0; k < 2; k++) begin
            if (src_valid) hs++;
            tick();
        end
        check_output("midreset.beats_before", 80'(hs), 80'd2);
        arstn = 1'b0;
        #1;
        check_output("midreset.src_valid", 80'(src_valid), 80'd0);
        check_output("midreset.done_valid", 80'(done_valid), 80'd0);
        check_output("midreset.cmd_ready", 80'(cmd_ready), 80'd0);
        tick();
        tick();
        arstn = 1'b1;
        exp_stall = 32'd0;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (src_valid || done_valid || !cmd_ready) bad++;
        end
        src_ready = 1'b0;
        check_output("midreset.idle_after", 80'(bad), 80'd0);
        check_output("midreset.stall_cnt", 80'(stall_cnt), 80'd0);

        // Longest legal RUN: all-ones count must not wrap.
        apply_stimulus(2'd2, 16'hFFFF, 64'h0, 0, 0, r);
        check_result("maxrun", 65535, 65'h0, 1'b1, 16'hFFFF, r);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
